// File: rtl/urv_dm_wb_bridge.sv
// urv_dm_wb_bridge
//
// Bridges the uRV CPU data-memory port to a pipelined-mode Wishbone master.
// Only one access is outstanding at a time. A load or store pulse seen in
// IDLE is latched and presented on the bus. The strobe is held while the
// slave stalls. The access completes on ack or err. A one-cycle done pulse
// (load or store) is then returned to the CPU. bus_err_o pulses alongside
// the done pulse when the access ends in error.
//
// Optional feature: define URV_DM_TIMEOUT_EN to enable a bus timeout. With
// the timeout, an access that sees no ack/err for g_timeout_cycles bus
// cycles is forced to complete as an error. Without it, the bridge waits
// indefinitely and g_timeout_cycles is unused.
//
// Ports
//   clk_i              single clock, rising edge
//   rst_i              synchronous active-high reset
//   dm_addr_i          CPU data address (valid with dm_load_i/dm_store_i)
//   dm_data_s_i        CPU store data
//   dm_data_select_i   CPU byte lane select
//   dm_load_i          one-cycle load request pulse
//   dm_store_i         one-cycle store request pulse (wins over a load)
//   dm_data_l_o        load data, held until the next load completes
//   dm_load_done_o     one-cycle load completion pulse
//   dm_store_done_o    one-cycle store completion pulse
//   wb_adr_o           Wishbone address (registered)
//   wb_dat_o           Wishbone write data (registered)
//   wb_sel_o           Wishbone byte select (registered)
//   wb_cyc_o           Wishbone cycle (registered)
//   wb_stb_o           Wishbone strobe (registered)
//   wb_we_o            Wishbone write enable (registered)
//   wb_dat_i           Wishbone read data
//   wb_ack_i           Wishbone acknowledge
//   wb_err_i           Wishbone error
//   wb_stall_i         Wishbone pipelined stall
//   bus_err_o          one-cycle pulse when an access ends in error/timeout

module urv_dm_wb_bridge #(
  parameter int unsigned g_timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,

  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,

  output logic        bus_err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] data_l_q, data_l_d;
  logic        load_done_q, load_done_d;
  logic        store_done_q, store_done_d;
  logic        bus_err_q, bus_err_d;

  logic        busy;
  logic        start;
  logic        resp_valid;
  logic        resp;
  logic        timeout_hit;
  logic        finish;
  logic        finish_err;

  // A bus access is in flight in REQ and WAIT.
  assign busy  = (state_q == StReq) || (state_q == StWait);
  assign start = (state_q == StIdle) && (dm_store_i || dm_load_i);

  // ack/err only count once the strobe has been accepted (or in WAIT).
  assign resp_valid = (state_q == StWait) || ((state_q == StReq) && !wb_stall_i);
  assign resp       = resp_valid && (wb_ack_i || wb_err_i);

`ifdef URV_DM_TIMEOUT_EN
  localparam int unsigned CntW = (g_timeout_cycles > 1) ? $clog2(g_timeout_cycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(g_timeout_cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts bus cycles already elapsed in this access; the hit fires in
  // the last allowed cycle so the access ends after exactly g_timeout_cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = busy && (cnt_q == CntLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A real ack in the same cycle as the timeout still counts as success.
  assign finish     = busy && (resp || timeout_hit);
  assign finish_err = (resp && wb_err_i) || (timeout_hit && !resp);

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    data_l_d     = data_l_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    bus_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = dm_store_i;
          adr_d   = dm_addr_i;
          dat_d   = dm_data_s_i;
          sel_d   = dm_data_select_i;
        end
      end
      StReq: begin
        if (!wb_stall_i) begin
          state_d = StWait;
          stb_d   = 1'b0;
        end
      end
      StWait: begin
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    // Completion overrides the REQ -> WAIT step above.
    if (finish) begin
      state_d      = StIdle;
      cyc_d        = 1'b0;
      stb_d        = 1'b0;
      load_done_d  = !we_q;
      store_done_d = we_q;
      bus_err_d    = finish_err;
      if (!we_q) begin
        data_l_d = finish_err ? 32'h0 : wb_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      dat_q        <= 32'h0;
      sel_q        <= 4'h0;
      data_l_q     <= 32'h0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      data_l_q     <= data_l_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign wb_cyc_o        = cyc_q;
  assign wb_stb_o        = stb_q;
  assign wb_we_o         = we_q;
  assign wb_adr_o        = adr_q;
  assign wb_dat_o        = dat_q;
  assign wb_sel_o        = sel_q;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign bus_err_o       = bus_err_q;

endmodule
